// File: rtl/uart_fifo_bridge_if.sv
// Host-side and uart-core-side signals of the FIFO bridge.
// The bridge takes the slave modport; its environment takes the master modport.
interface uart_fifo_bridge_if #(
  parameter int unsigned addr_w = 4
);
  logic [7:0]      host_tx_data;
  logic            host_tx_wr;
  logic            host_tx_full;
  logic [addr_w:0] host_tx_level;
  logic [7:0]      host_rx_data;
  logic            host_rx_rd;
  logic            host_rx_empty;
  logic [addr_w:0] host_rx_level;
  logic            host_clr_err;
  logic            overrun;
  logic            frame_err;
  logic [7:0]      tx_data;
  logic            tx_wr;
  logic            tx_busy;
  logic [7:0]      rx_data;
  logic            rx_avail;
  logic            rx_error;
  logic            rx_ack;

  modport master (
    output host_tx_data, host_tx_wr, host_rx_rd, host_clr_err,
    output tx_busy, rx_data, rx_avail, rx_error,
    input  host_tx_full, host_tx_level, host_rx_data, host_rx_empty, host_rx_level,
    input  overrun, frame_err, tx_data, tx_wr, rx_ack
  );

  modport slave (
    input  host_tx_data, host_tx_wr, host_rx_rd, host_clr_err,
    input  tx_busy, rx_data, rx_avail, rx_error,
    output host_tx_full, host_tx_level, host_rx_data, host_rx_empty, host_rx_level,
    output overrun, frame_err, tx_data, tx_wr, rx_ack
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// TX/RX byte FIFOs between a host register interface and a uart core,
// with one-byte-in-flight TX handshake, acked RX capture and sticky error flags.
module uart_fifo_bridge #(
  parameter int unsigned addr_w = 4
) (
  input logic              clk,
  input logic              reset,
  uart_fifo_bridge_if.slave bus
);
  localparam int unsigned     DEPTH    = 1 << addr_w;
  localparam logic [addr_w:0] FULL_LVL = (addr_w + 1)'(DEPTH);
  localparam logic [addr_w:0] ONE      = (addr_w + 1)'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_STROBE, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_e;
  typedef enum logic {RX_IDLE, RX_ACK} rx_state_e;

  tx_state_e         tx_state_q;
  rx_state_e         rx_state_q;

  logic [7:0]        tx_mem_q [DEPTH];
  logic [addr_w-1:0] tx_wptr_q, tx_rptr_q;
  logic [addr_w:0]   tx_level_q, tx_level_d;
  logic [7:0]        rx_mem_q [DEPTH];
  logic [addr_w-1:0] rx_wptr_q, rx_rptr_q;
  logic [addr_w:0]   rx_level_q, rx_level_d;

  logic [7:0]        tx_data_q;
  logic              tx_wr_q, rx_ack_q, overrun_q, frame_err_q;

  logic tx_full, tx_empty, tx_push, tx_pop;
  logic rx_full, rx_empty, rx_push, rx_pop;
  logic overrun_set, frame_set;

  assign tx_full  = (tx_level_q == FULL_LVL);
  assign tx_empty = (tx_level_q == '0);
  assign rx_full  = (rx_level_q == FULL_LVL);
  assign rx_empty = (rx_level_q == '0);

  // Push acceptance looks only at the registered full flag, so a same-cycle pop never frees a slot.
  assign tx_push = bus.host_tx_wr && !tx_full;
  assign tx_pop  = (tx_state_q == TX_IDLE) && !tx_empty;
  assign rx_push = (rx_state_q == RX_IDLE) && bus.rx_avail && !rx_full;
  assign rx_pop  = bus.host_rx_rd && !rx_empty;

  assign overrun_set = (rx_state_q == RX_IDLE) && bus.rx_avail && rx_full;
  assign frame_set   = (rx_state_q == RX_IDLE) && !bus.rx_avail && bus.rx_error;

  always_comb begin
    tx_level_d = tx_level_q;
    if (tx_push && !tx_pop) tx_level_d = tx_level_q + ONE;
    else if (!tx_push && tx_pop) tx_level_d = tx_level_q - ONE;
  end

  always_comb begin
    rx_level_d = rx_level_q;
    if (rx_push && !rx_pop) rx_level_d = rx_level_q + ONE;
    else if (!rx_push && rx_pop) rx_level_d = rx_level_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= bus.host_tx_data;
    if (rx_push) rx_mem_q[rx_wptr_q] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_level_q <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_level_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      tx_level_q <= tx_level_d;
      rx_level_q <= rx_level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_wr_q    <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_data_q  <= tx_mem_q[tx_rptr_q];
            tx_wr_q    <= 1'b1;
            tx_state_q <= TX_STROBE;
          end
        end
        TX_STROBE: begin
          tx_wr_q    <= 1'b0;
          tx_state_q <= TX_WAIT_BUSY;
        end
        TX_WAIT_BUSY: if (bus.tx_busy) tx_state_q <= TX_WAIT_DONE;
        TX_WAIT_DONE: if (!bus.tx_busy) tx_state_q <= TX_IDLE;
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q  <= RX_IDLE;
      rx_ack_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (bus.rx_avail || bus.rx_error) begin
            rx_ack_q   <= 1'b1;
            rx_state_q <= RX_ACK;
          end
        end
        RX_ACK: begin
          rx_ack_q   <= 1'b0;
          rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
      if (overrun_set) overrun_q <= 1'b1;
      else if (bus.host_clr_err) overrun_q <= 1'b0;
      if (frame_set) frame_err_q <= 1'b1;
      else if (bus.host_clr_err) frame_err_q <= 1'b0;
    end
  end

  assign bus.host_tx_full  = tx_full;
  assign bus.host_tx_level = tx_level_q;
  assign bus.host_rx_data  = rx_mem_q[rx_rptr_q];
  assign bus.host_rx_empty = rx_empty;
  assign bus.host_rx_level = rx_level_q;
  assign bus.overrun       = overrun_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_wr         = tx_wr_q;
  assign bus.rx_ack        = rx_ack_q;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Randomized and directed bench for uart_fifo_bridge against a queue-based reference model.
module tb_uart_fifo_bridge;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_fifo_bridge_if #(.addr_w(AW)) bif ();
  uart_fifo_bridge #(.addr_w(AW)) dut (.clk(clk), .reset(rst), .bus(bif));

  // reference model
  logic [7:0] m_txq[$];
  logic [7:0] m_rxq[$];
  int         m_tx_phase = 0;
  logic       m_tx_wr = 1'b0;
  logic [7:0] m_tx_data = '0;
  logic       m_rx_in_ack = 1'b0;
  logic       m_ack = 1'b0, m_ovr = 1'b0, m_fe = 1'b0;

  // uart core behaviour and observation
  bit         busy_hold = 0;
  int         busy_cnt = 0;
  int         busy_len = 20;
  logic       prev_tx_wr = 1'b0, prev_ack = 1'b0;
  int         tx_pulses = 0, rx_acks = 0;
  logic [7:0] got_tx[$];

  int n_cmp = 0, n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  txs, rxs;
    bit  do_rx_push, ovr_set, fe_set;
    txs = m_txq.size();
    rxs = m_rxq.size();
    do_rx_push = 0; ovr_set = 0; fe_set = 0;
    if (rst) begin
      m_txq.delete(); m_rxq.delete();
      m_tx_phase = 0; m_tx_wr = 0; m_tx_data = '0;
      m_rx_in_ack = 0; m_ack = 0; m_ovr = 0; m_fe = 0;
    end else begin
      // phase: 0 ready, 1 strobe, 2 awaiting busy rise, 3 awaiting busy fall
      case (m_tx_phase)
        0: if (txs > 0) begin m_tx_data = m_txq.pop_front(); m_tx_wr = 1; m_tx_phase = 1; end
        1: begin m_tx_wr = 0; m_tx_phase = 2; end
        2: if (bif.tx_busy) m_tx_phase = 3;
        default: if (!bif.tx_busy) m_tx_phase = 0;
      endcase
      if (bif.host_tx_wr && txs < DEPTH) m_txq.push_back(bif.host_tx_data);

      if (m_rx_in_ack) begin
        m_ack = 0; m_rx_in_ack = 0;
      end else if (bif.rx_avail) begin
        m_ack = 1; m_rx_in_ack = 1;
        if (rxs < DEPTH) do_rx_push = 1; else ovr_set = 1;
      end else if (bif.rx_error) begin
        m_ack = 1; m_rx_in_ack = 1; fe_set = 1;
      end
      if (bif.host_rx_rd && rxs > 0) void'(m_rxq.pop_front());
      if (do_rx_push) m_rxq.push_back(bif.rx_data);
      if (ovr_set) m_ovr = 1; else if (bif.host_clr_err) m_ovr = 0;
      if (fe_set) m_fe = 1; else if (bif.host_clr_err) m_fe = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("tx_level", 32'(bif.host_tx_level), m_txq.size());
    check_eq("tx_full", 32'(bif.host_tx_full), 32'(m_txq.size() == DEPTH));
    check_eq("rx_level", 32'(bif.host_rx_level), m_rxq.size());
    check_eq("rx_empty", 32'(bif.host_rx_empty), 32'(m_rxq.size() == 0));
    if (m_rxq.size() > 0) check_eq("rx_head", 32'(bif.host_rx_data), 32'(m_rxq[0]));
    check_eq("tx_wr", 32'(bif.tx_wr), 32'(m_tx_wr));
    check_eq("tx_data", 32'(bif.tx_data), 32'(m_tx_data));
    check_eq("rx_ack", 32'(bif.rx_ack), 32'(m_ack));
    check_eq("overrun", 32'(bif.overrun), 32'(m_ovr));
    check_eq("frame_err", 32'(bif.frame_err), 32'(m_fe));

    if (bif.tx_wr) begin
      if (!busy_hold) check_eq("busy_low_at_wr", 32'(bif.tx_busy), 0);
      tx_pulses++;
      got_tx.push_back(bif.tx_data);
    end
    if (prev_tx_wr) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    bif.tx_busy = busy_hold || (busy_cnt > 0);
    prev_tx_wr = bif.tx_wr;

    if (prev_ack) begin bif.rx_avail = 0; bif.rx_error = 0; end
    prev_ack = bif.rx_ack;
    if (bif.rx_ack) rx_acks++;

    bif.host_tx_wr = 0;
    bif.host_rx_rd = 0;
    bif.host_clr_err = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push_tx(input logic [7:0] d);
    bif.host_tx_data = d;
    bif.host_tx_wr = 1;
    step();
  endtask

  task automatic set_hold(input bit h);
    busy_hold = h;
    bif.tx_busy = h || (busy_cnt > 0);
  endtask

  task automatic rx_present(input logic [7:0] d, input bit err);
    int n;
    n = 0;
    while ((bif.rx_avail || bif.rx_error) && n < 50) begin step(); n++; end
    check_eq("rx_line_free", 32'(bif.rx_avail | bif.rx_error), 0);
    bif.rx_data = d;
    bif.rx_avail = !err;
    bif.rx_error = err;
    step();
  endtask

  task automatic drain_tx();
    int n;
    n = 0;
    while ((m_txq.size() > 0 || m_tx_phase != 0 || busy_cnt > 0) && n < 2000) begin step(); n++; end
    check_eq("tx_drain_done", 32'(bif.host_tx_level), 0);
  endtask

  initial begin
    int a0, p0, lvl;
    logic [7:0] d;
    rst = 1;
    bif.host_tx_data = '0; bif.host_tx_wr = 0; bif.host_rx_rd = 0; bif.host_clr_err = 0;
    bif.tx_busy = 0; bif.rx_data = '0; bif.rx_avail = 0; bif.rx_error = 0;
    idle(2);
    check_eq("reset_rx_empty", 32'(bif.host_rx_empty), 1);
    check_eq("reset_tx_data", 32'(bif.tx_data), 0);
    rst = 0;

    // two bytes through a 20-cycle busy core
    tx_pulses = 0; got_tx.delete();
    push_tx(8'h55);
    push_tx(8'hA3);
    drain_tx();
    idle(5);
    check_eq("t1_pulses", tx_pulses, 2);
    check_eq("t1_byte0", 32'(got_tx[0]), 32'h55);
    check_eq("t1_byte1", 32'(got_tx[1]), 32'hA3);

    // fill TX while a byte is stuck in flight; the 17th push is dropped
    tx_pulses = 0; got_tx.delete();
    set_hold(1);
    push_tx(8'hEE);
    idle(4);
    for (int i = 0; i < 17; i++) push_tx(8'(i));
    check_eq("t2_full", 32'(bif.host_tx_full), 1);
    check_eq("t2_level", 32'(bif.host_tx_level), 16);
    set_hold(0);
    drain_tx();
    idle(3);
    check_eq("t2_count", got_tx.size(), 17);
    for (int i = 0; i < 16; i++) check_eq("t2_order", 32'(got_tx[i + 1]), i);

    // two received bytes, first-word-fall-through reads
    a0 = rx_acks;
    rx_present(8'h3C, 0);
    rx_present(8'hC3, 0);
    idle(3);
    check_eq("t3_acks", rx_acks - a0, 2);
    check_eq("t3_head0", 32'(bif.host_rx_data), 32'h3C);
    check_eq("t3_nonempty", 32'(bif.host_rx_empty), 0);
    bif.host_rx_rd = 1; step();
    check_eq("t3_head1", 32'(bif.host_rx_data), 32'hC3);
    bif.host_rx_rd = 1; step();
    check_eq("t3_empty", 32'(bif.host_rx_empty), 1);

    // RX overrun
    a0 = rx_acks;
    for (int i = 0; i < 17; i++) rx_present(8'($urandom), 0);
    idle(3);
    check_eq("t4_level", 32'(bif.host_rx_level), 16);
    check_eq("t4_overrun", 32'(bif.overrun), 1);
    check_eq("t4_acks", rx_acks - a0, 17);
    bif.host_clr_err = 1; step();
    check_eq("t4_clr", 32'(bif.overrun), 0);
    for (int i = 0; i < 16; i++) begin bif.host_rx_rd = 1; step(); end
    check_eq("t4_drained", 32'(bif.host_rx_empty), 1);

    // framing error, then set-wins against clear
    a0 = rx_acks;
    lvl = int'(bif.host_rx_level);
    rx_present(8'h00, 1);
    idle(3);
    check_eq("t5_fe", 32'(bif.frame_err), 1);
    check_eq("t5_acks", rx_acks - a0, 1);
    check_eq("t5_level", 32'(bif.host_rx_level), lvl);
    bif.rx_error = 1; bif.host_clr_err = 1; step();
    check_eq("t5_set_wins", 32'(bif.frame_err), 1);
    idle(3);
    bif.host_clr_err = 1; step();
    check_eq("t5_clr", 32'(bif.frame_err), 0);

    // reset while a byte waits on busy, with data queued both ways
    set_hold(1);
    for (int i = 0; i < 6; i++) push_tx(8'(8'h80 + i));
    for (int i = 0; i < 3; i++) rx_present(8'(8'h40 + i), 0);
    rx_present(8'h00, 1);
    idle(3);
    check_eq("t6_pre_tx", 32'(bif.host_tx_level), 5);
    check_eq("t6_pre_rx", 32'(bif.host_rx_level), 3);
    check_eq("t6_pre_fe", 32'(bif.frame_err), 1);
    rst = 1; step(); rst = 0;
    check_eq("t6_tx_level", 32'(bif.host_tx_level), 0);
    check_eq("t6_rx_level", 32'(bif.host_rx_level), 0);
    check_eq("t6_tx_wr", 32'(bif.tx_wr), 0);
    check_eq("t6_ack", 32'(bif.rx_ack), 0);
    check_eq("t6_fe", 32'(bif.frame_err), 0);
    set_hold(0);
    p0 = tx_pulses;
    idle(40);
    check_eq("t6_no_tx", tx_pulses - p0, 0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(2, 0) == 0) begin
        bif.host_tx_wr = 1;
        bif.host_tx_data = 8'($urandom);
      end
      bif.host_rx_rd = ((c / 200) % 2 == 1) ? 1'b0 : ($urandom_range(2, 0) == 0);
      bif.host_clr_err = ($urandom_range(19, 0) == 0);
      if (!bif.rx_avail && !bif.rx_error && $urandom_range(3, 0) == 0) begin
        d = 8'($urandom);
        bif.rx_data = d;
        if ($urandom_range(7, 0) == 0) bif.rx_error = 1;
        else bif.rx_avail = 1;
      end
      busy_len = int'($urandom_range(6, 1));
      step();
    end
    drain_tx();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
